mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
Shares the single CPU-side port of the memory controller between two requesters (req 0 = instruction fetch, req 1 = load/store).
- Round-robin arbitration; one transaction outstanding at a time.
- Latches the winning request and drives the controller's Valid/RW/Addr interface.
- Tracks the controller's Ready low→high completion and returns read data with a one-cycle ack.
- Sits between the CPU front end and the memory controller.

Parameters:
AWIDTH, 16, request address width (matches controller Addr_in)
DWIDTH, 32, data width
TMO_CYCLES, 16, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-requester request strobe, held until ack
req_rw  input  2  per-requester op: 0 = write, 1 = read
req_addr  input  2*AWIDTH  packed addresses, [AWIDTH-1:0] = req 0
req_wdata  input  2*DWIDTH  packed write data, [DWIDTH-1:0] = req 0
req_ack  output  2  one-cycle completion pulse to the granted requester
req_err  output  1  valid with req_ack; 1 = transaction timed out
rdata  output  DWIDTH  read data, valid in the req_ack cycle of a read
mc_valid  output  1  to controller Valid
mc_rw  output  1  to controller RW
mc_addr  output  AWIDTH  to controller Addr_in
mc_wdata  output  DWIDTH  write data; integration drives the bidirectional Data_in only when mc_rw = 0
mc_rdata  input  DWIDTH  read data sampled from the controller Data_in bus
mc_ready  input  1  controller Ready
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; last_grant = 1, so req 0 wins the first tie.
  - All outputs 0: req_ack, req_err, rdata, mc_valid, mc_rw, mc_addr, mc_wdata, busy.
  - Reset mid-transaction aborts it: mc_valid drops immediately and no ack is issued.
- IDLE:
  - mc_ready is ignored (it may be X after power-up).
  - If any req_valid bit is set, grant by round-robin:
    - Single requester: it wins.
    - Both requesting: the requester ≠ last_grant wins.
  - Latch rw/addr/wdata of the winner into internal registers and record g = winner; → ISSUE.
- ISSUE:
  - mc_valid = 1; mc_rw/mc_addr/mc_wdata come from the latched registers and stay stable until IDLE.
  - mc_ready == 0 sampled (controller accepted) → WAIT; mc_valid = 0 from the next cycle.
- WAIT: mc_ready == 1 sampled → RESP. If the op is a read, capture mc_rdata into rdata on that edge.
- RESP:
  - req_ack[g] = 1 for exactly one cycle; req_err = 0; last_grant = g; → IDLE.
  - rdata holds its value until the next read completes.
- Latency: with a 2-cycle controller, req_valid rise → req_ack = 5 cycles (IDLE, ISSUE, WAIT×2, RESP).
- Requester rules:
  - Drop req_valid in the cycle after ack. A level still high in IDLE is treated as a new request.
  - A req_valid deasserted after latching does not cancel the transaction; the ack still pulses.
- The non-granted requester's inputs are ignored until IDLE. Its pending req_valid is served next, so neither requester can starve.
- Address bits above the controller width are passed through unchanged; truncation happens in the controller.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - An 8-bit counter clears on entry to ISSUE and increments in ISSUE/WAIT.
  - On reaching TMO_CYCLES: mc_valid = 0, → RESP with req_err = 1 and rdata unchanged.
  - last_grant is updated as normal.
- Undefined: no counter is built; req_err is tied 0; the arbiter waits indefinitely for mc_ready.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding constants: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3.
  - Op encodings OP_WR = 1'b0, OP_RD = 1'b1.
  - Default AWIDTH/DWIDTH.
- Sub-module rr_arb2: combinational 2-way round-robin grant, inputs req[1:0] and last_grant, outputs a one-hot grant.
- FSM, latches and watchdog live in the top module.

Test Plan:
- Single read: req0 read addr 0x0012 with the controller model returning 0xDEADBEEF → mc_valid high in ISSUE, mc_addr = 0x0012, mc_rw = 1; req_ack = 2'b01 in cycle 5 with rdata = 0xDEADBEEF.
- Single write: req1 write addr 0x0034, data 0x0000A5A5 → mc_rw = 0, mc_wdata = 0x0000A5A5 held through WAIT; req_ack = 2'b10; rdata unchanged.
- Simultaneous requests after reset: both valid, held after ack → grants alternate 0,1,0,1 over four transactions.
- Mid-transaction reset: assert rst_n = 0 in WAIT → mc_valid, busy and req_ack are 0 immediately; after release, the first grant goes to req 0.
- Early deassert: req0 drops valid in ISSUE → transaction completes and req_ack[0] still pulses once.
- ARB_TIMEOUT_EN with TMO_CYCLES = 16 and mc_ready stuck at 1 → RESP after 16 cycles in ISSUE/WAIT, req_ack[0] = 1 with req_err = 1; without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory access arbiter.
package mem_arb_pkg;

    localparam int AWIDTH_DEF = 16;
    localparam int DWIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/mem_access_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant. On a tie the requester that
// did not win last time is granted; the output is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Single requester wins outright; on a tie favour the one not granted last.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the memory controller's single CPU port between instruction fetch
// (req 0) and load/store (req 1). One transaction outstanding at a time.
// Optional watchdog: define ARB_TIMEOUT_EN to abort transactions whose
// controller never completes within TMO_CYCLES cycles (reported on req_err).
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH     = AWIDTH_DEF,
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int TMO_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_rw,
    input  logic [2*AWIDTH-1:0] req_addr,
    input  logic [2*DWIDTH-1:0] req_wdata,
    output logic [1:0]          req_ack,
    output logic                req_err,
    output logic [DWIDTH-1:0]   rdata,
    output logic                mc_valid,
    output logic                mc_rw,
    output logic [AWIDTH-1:0]   mc_addr,
    output logic [DWIDTH-1:0]   mc_wdata,
    input  logic [DWIDTH-1:0]   mc_rdata,
    input  logic                mc_ready,
    output logic                busy
);

    state_t              state, state_nxt;
    logic                last_grant;
    logic                g;
    logic                rw_q;
    logic [AWIDTH-1:0]   addr_q;
    logic [DWIDTH-1:0]   wdata_q;
    logic [DWIDTH-1:0]   rdata_q;
    logic [1:0]          grant;
    logic                win;
    logic                start;
    logic                done;
    logic                tmo_hit;

    rr_arb2 u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign win   = grant[1];
    assign start = (state == IDLE) && (|grant);
    // Normal completion wins over a timeout landing on the same edge.
    assign done  = (state == WAIT) && mc_ready;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    assign tmo_hit = ((state == ISSUE) || (state == WAIT)) && !done &&
                     (tmo_cnt == 8'(TMO_CYCLES - 1));

    // Watchdog: cleared on entry to ISSUE, counts every ISSUE/WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            if (start) begin
                tmo_cnt <= 8'd0;
                err_q   <= 1'b0;
            end else if ((state == ISSUE) || (state == WAIT)) begin
                tmo_cnt <= tmo_cnt + 8'd1;
                if (tmo_hit)
                    err_q <= 1'b1;
            end
        end
    end

    assign req_err = (state == RESP) && err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYCLES;
    assign tmo_hit    = 1'b0;
    assign req_err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; mc_ready is only looked at once a request is issued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start)     state_nxt = ISSUE;
            ISSUE: if (tmo_hit)   state_nxt = RESP;
                   else if (!mc_ready) state_nxt = WAIT;
            WAIT:  if (done || tmo_hit) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's request; capture read data; update round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            g          <= 1'b0;
            rw_q       <= OP_WR;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (start) begin
                g       <= win;
                rw_q    <= req_rw[win];
                addr_q  <= win ? req_addr[2*AWIDTH-1:AWIDTH]   : req_addr[AWIDTH-1:0];
                wdata_q <= win ? req_wdata[2*DWIDTH-1:DWIDTH] : req_wdata[DWIDTH-1:0];
            end
            if (done && (rw_q == OP_RD))
                rdata_q <= mc_rdata;
            if (state == RESP)
                last_grant <= g;
        end
    end

    assign mc_valid = (state == ISSUE);
    assign mc_rw    = rw_q;
    assign mc_addr  = addr_q;
    assign mc_wdata = wdata_q;
    assign rdata    = rdata_q;
    assign busy     = (state != IDLE);
    assign req_ack  = (state == RESP) ? (g ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter with a small 2-cycle controller model.
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_rw;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ack;
    logic        req_err;
    logic [31:0] rdata;
    logic        mc_valid, mc_rw;
    logic [15:0] mc_addr;
    logic [31:0] mc_wdata, mc_rdata;
    logic        mc_ready;
    logic        busy;

    logic [1:0]  mcnt;
    logic        stuck;
    int          cyc = 0;
    int          tests = 0;
    int          errors = 0;

    typedef struct { logic [1:0] ack; logic err; logic [31:0] rd; int start; int lat; } exp_t;
    typedef struct { logic rw; logic [15:0] addr; logic [31:0] wdata; } iss_t;
    exp_t exp_q[$];
    iss_t iss_q[$];
    logic [31:0] exp_rd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_err(req_err), .rdata(rdata),
        .mc_valid(mc_valid), .mc_rw(mc_rw), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_rdata(mc_rdata), .mc_ready(mc_ready), .busy(busy)
    );

    // Controller model: Ready drops while Valid is seen, stays low one more
    // cycle, then rises with the data. 'stuck' forces Ready high forever.
    assign mc_ready = stuck | !(mc_valid || (mcnt != 2'd0));
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          mcnt <= 2'd0;
        else if (mc_valid && mcnt == 2'd0)   mcnt <= 2'd1;
        else if (mcnt != 2'd0)               mcnt <= mcnt - 2'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        errors++;
        $display("FAIL %s: got event expected none/other", name);
    endtask

    task automatic drive(input int i, input logic rw, input logic [15:0] a, input logic [31:0] d);
        req_valid[i]          = 1'b1;
        req_rw[i]             = rw;
        req_addr[i*16 +: 16]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic push(input int i, input logic rw, input logic [15:0] a, input logic [31:0] d,
                        input logic err, input int lat);
        exp_t e;
        iss_t s;
        s.rw = rw; s.addr = a; s.wdata = d;
        iss_q.push_back(s);
        e.ack = (i == 1) ? 2'b10 : 2'b01;
        e.err = err; e.rd = exp_rd; e.start = cyc; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ack == 2'b00 && n < 100);
        if (req_ack == 2'b00) fail_now("ack_timeout");
    endtask

    // Monitor: compares controller-side issue and requester acks against the queues.
    initial begin
        iss_t cur;
        logic pv = 1'b0;
        exp_t e;
        cur.rw = 1'b0; cur.addr = '0; cur.wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (mc_valid && !pv) begin
                    if (iss_q.size() == 0) fail_now("unexpected_issue");
                    else begin
                        cur = iss_q.pop_front();
                        chk("issue_rw", mc_rw, cur.rw);
                        chk("issue_addr", mc_addr, cur.addr);
                        if (!cur.rw) chk("issue_wdata", mc_wdata, cur.wdata);
                    end
                end
                if (busy && !mc_valid && req_ack == 2'b00) begin
                    chk("hold_rw", mc_rw, cur.rw);
                    chk("hold_addr", mc_addr, cur.addr);
                    if (!cur.rw) chk("hold_wdata", mc_wdata, cur.wdata);
                end
                if (req_ack != 2'b00) begin
                    if (exp_q.size() == 0) fail_now("unexpected_ack");
                    else begin
                        e = exp_q.pop_front();
                        chk("ack", req_ack, e.ack);
                        chk("err", req_err, e.err);
                        chk("rdata", rdata, e.rd);
                        if (e.lat != 0) chk("latency", cyc - e.start, e.lat);
                    end
                end
                pv = mc_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        req_valid = 2'b00; req_rw = 2'b00; req_addr = '0; req_wdata = '0;
        stuck = 1'b0; mc_rdata = '0; exp_rd = '0;
        rst_n = 1'b0;
        #2;
        chk("rst_ack", req_ack, 0);
        chk("rst_err", req_err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mc_valid", mc_valid, 0);
        chk("rst_mc_rw", mc_rw, 0);
        chk("rst_mc_addr", mc_addr, 0);
        chk("rst_mc_wdata", mc_wdata, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read by req 0, 5-cycle latency.
        mc_rdata = 32'hDEADBEEF;
        exp_rd   = 32'hDEADBEEF;
        push(0, 1'b1, 16'h0012, 32'h0, 1'b0, 4);
        drive(0, 1'b1, 16'h0012, 32'h0);
        wait_ack();
        req_valid = 2'b00;
        @(negedge clk);

        // Single write by req 1; rdata keeps the previous read.
        push(1, 1'b0, 16'h0034, 32'h0000A5A5, 1'b0, 4);
        drive(1, 1'b0, 16'h0034, 32'h0000A5A5);
        wait_ack();
        req_valid = 2'b00;
        @(negedge clk);

        // Both requesting after reset: grants alternate 0,1,0,1.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rd = 32'h0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push(0, 1'b0, 16'h0100, 32'h1, 1'b0, 0);
            else            push(1, 1'b0, 16'h0200, 32'h2, 1'b0, 0);
        end
        drive(0, 1'b0, 16'h0100, 32'h1);
        drive(1, 1'b0, 16'h0200, 32'h2);
        for (int k = 0; k < 4; k++) wait_ack();
        req_valid = 2'b00;
        @(negedge clk);

        // Reset in WAIT aborts the read; afterwards req 0 wins the first tie.
        mc_rdata = 32'hCAFEF00D;
        begin
            iss_t s;
            s.rw = 1'b1; s.addr = 16'h0044; s.wdata = 32'h0;
            iss_q.push_back(s);
        end
        drive(0, 1'b1, 16'h0044, 32'h0);
        n = 0;
        while (!(busy && !mc_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(busy && !mc_valid)) fail_now("wait_state_timeout");
        rst_n = 1'b0;
        #1;
        chk("abort_mc_valid", mc_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ack", req_ack, 0);
        chk("abort_rdata", rdata, 0);
        @(negedge clk);
        exp_rd = 32'hCAFEF00D;
        push(0, 1'b1, 16'h0044, 32'h0, 1'b0, 4);
        drive(1, 1'b0, 16'h0088, 32'h3);
        rst_n = 1'b1;
        wait_ack();
        req_valid = 2'b00;
        @(negedge clk);

        // Early deassert in ISSUE: ack still pulses exactly once.
        mc_rdata = 32'h12345678;
        exp_rd   = 32'h12345678;
        push(0, 1'b1, 16'h0056, 32'h0, 1'b0, 4);
        drive(0, 1'b1, 16'h0056, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mc_valid && n < 50);
        if (!mc_valid) fail_now("issue_timeout");
        req_valid = 2'b00;
        wait_ack();
        repeat (4) @(negedge clk);

        // Controller never completes (Ready stuck high).
        stuck = 1'b1;
`ifdef ARB_TIMEOUT_EN
        push(0, 1'b1, 16'h0066, 32'h0, 1'b1, 17);
        drive(0, 1'b1, 16'h0066, 32'h0);
        wait_ack();
        req_valid = 2'b00;
        @(negedge clk);
        chk("tmo_idle_busy", busy, 0);
        stuck = 1'b0;
`else
        begin
            iss_t s;
            s.rw = 1'b1; s.addr = 16'h0066; s.wdata = 32'h0;
            iss_q.push_back(s);
        end
        drive(0, 1'b1, 16'h0066, 32'h0);
        repeat (40) @(negedge clk);
        chk("stuck_busy", busy, 1);
        chk("stuck_ack", req_ack, 0);
        chk("stuck_mc_valid", mc_valid, 1);
        rst_n = 1'b0;
        req_valid = 2'b00;
        stuck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk("pending_acks", exp_q.size(), 0);
        chk("pending_issues", iss_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
